// File: rtl/pci_bus_arbiter_if.sv
// rtl/pci_bus_arbiter_if.sv - PCI arbiter request/grant bundle
// Signals:
//   req_n       per-master request, active low (masters -> arbiter)
//   frame_n     PCI FRAME#, active low (bus -> arbiter)
//   irdy_n      PCI IRDY#, active low (bus -> arbiter)
//   gnt_n       per-master grant, active low, one-hot or all ones (arbiter -> masters)
//   owner       index of current or last granted master
//   bus_busy    arbiter is tracking a transfer in progress
//   timeout_err one-cycle pulse when an unused grant is revoked
// Modports: slave = arbiter side, master = requester/bus side.
interface pci_bus_arbiter_if #(
    parameter int N_MASTERS = 4
);
    logic [N_MASTERS-1:0] req_n;
    logic                 frame_n;
    logic                 irdy_n;
    logic [N_MASTERS-1:0] gnt_n;
    logic [2:0]           owner;
    logic                 bus_busy;
    logic                 timeout_err;

    modport slave (
        input  req_n, frame_n, irdy_n,
        output gnt_n, owner, bus_busy, timeout_err
    );

    modport master (
        output req_n, frame_n, irdy_n,
        input  gnt_n, owner, bus_busy, timeout_err
    );
endinterface

// File: rtl/pci_bus_arbiter.sv
// rtl/pci_bus_arbiter.sv - round-robin PCI bus arbiter with parking and grant timeout
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  pci_bus_arbiter_if.slave: req_n/frame_n/irdy_n in, gnt_n/owner/bus_busy/timeout_err out
// Optional feature macro: ARB_GNT_TIMEOUT_EN enables the GRANT-state timer that revokes
// an unused grant after GNT_TIMEOUT cycles and pulses timeout_err; undefined, the grant
// waits indefinitely and timeout_err is tied 0.
module pci_bus_arbiter #(
    parameter int N_MASTERS   = 4,
    parameter int PARK_MASTER = 0,
    parameter int GNT_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    pci_bus_arbiter_if.slave       bus
);
    localparam int IDX_W = $clog2(N_MASTERS);
    localparam logic [N_MASTERS-1:0] ONE_HOT0 = {{(N_MASTERS-1){1'b0}}, 1'b1};

    if (N_MASTERS < 2 || N_MASTERS > 8) begin : g_bad_n_masters
        $error("pci_bus_arbiter: N_MASTERS out of range 2..8");
    end
    if (PARK_MASTER < 0 || PARK_MASTER >= N_MASTERS) begin : g_bad_park
        $error("pci_bus_arbiter: PARK_MASTER must be below N_MASTERS");
    end
    if (GNT_TIMEOUT < 2 || GNT_TIMEOUT > 255) begin : g_bad_timeout
        $error("pci_bus_arbiter: GNT_TIMEOUT out of range 2..255");
    end

    typedef enum logic [1:0] {S_PARK, S_TURN, S_GRANT, S_BUSY} state_t;

    state_t               r_state, w_state_nxt;
    logic [2:0]           r_owner, w_owner_nxt;
    logic [2:0]           r_last_owner, w_last_nxt;
    logic [N_MASTERS-1:0] r_gnt_n, w_gnt_nxt;
    logic                 r_bus_busy, w_busy_nxt;
    logic [2:0]           w_winner;
    logic                 w_found;
    logic                 w_any_req;
    logic                 w_other_req;
    logic                 w_owner_req;
    logic                 w_bus_idle;
`ifdef ARB_GNT_TIMEOUT_EN
    logic [7:0]           r_timer, w_timer_nxt;
    logic                 r_timeout_err, w_timeout;
`endif

    assign w_bus_idle  = bus.frame_n & bus.irdy_n;
    assign w_any_req   = ~&bus.req_n;
    assign w_owner_req = ~bus.req_n[r_owner[IDX_W-1:0]];
    assign w_other_req = |(~bus.req_n & ~(ONE_HOT0 << r_owner));

    // Round-robin search starting just after the last master that got the bus.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_last_owner;
        for (int i = 1; i <= N_MASTERS; i++) begin
            if (!w_found && !bus.req_n[IDX_W'((int'(r_last_owner) + i) % N_MASTERS)]) begin
                w_found  = 1'b1;
                w_winner = 3'((int'(r_last_owner) + i) % N_MASTERS);
            end
        end
    end

    // State register, including the registered outputs computed for the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_TURN;
            r_owner       <= 3'(PARK_MASTER);
            r_last_owner  <= 3'(N_MASTERS - 1);
            r_gnt_n       <= '1;
            r_bus_busy    <= 1'b0;
`ifdef ARB_GNT_TIMEOUT_EN
            r_timer       <= 8'd0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_owner       <= w_owner_nxt;
            r_last_owner  <= w_last_nxt;
            r_gnt_n       <= w_gnt_nxt;
            r_bus_busy    <= w_busy_nxt;
`ifdef ARB_GNT_TIMEOUT_EN
            r_timer       <= w_timer_nxt;
            r_timeout_err <= w_timeout;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last_owner;
`ifdef ARB_GNT_TIMEOUT_EN
        w_timer_nxt = r_timer;
        w_timeout   = 1'b0;
`endif
        case (r_state)
            S_TURN: begin
                if (w_any_req) begin
                    w_state_nxt = S_GRANT;
                    w_owner_nxt = w_winner;
`ifdef ARB_GNT_TIMEOUT_EN
                    w_timer_nxt = 8'd0;
`endif
                end else begin
                    w_state_nxt = S_PARK;
                    w_owner_nxt = 3'(PARK_MASTER);
                end
            end
            S_PARK: begin
                if (!bus.frame_n) begin
                    // Parked master may start a transfer without having requested.
                    w_state_nxt = S_BUSY;
                    w_last_nxt  = r_owner;
                end else if (w_any_req && w_winner == 3'(PARK_MASTER)) begin
                    // Grant already sits on this master, so no turnaround is needed.
                    w_state_nxt = S_GRANT;
`ifdef ARB_GNT_TIMEOUT_EN
                    w_timer_nxt = 8'd0;
`endif
                end else if (w_any_req) begin
                    w_state_nxt = S_TURN;
                end
            end
            S_GRANT: begin
`ifdef ARB_GNT_TIMEOUT_EN
                w_timer_nxt = r_timer + 8'd1;
`endif
                if (!bus.frame_n) begin
                    w_state_nxt = S_BUSY;
                    w_last_nxt  = r_owner;
`ifdef ARB_GNT_TIMEOUT_EN
                    w_timer_nxt = 8'd0;
`endif
                end else if (!w_owner_req) begin
                    w_state_nxt = S_TURN;
`ifdef ARB_GNT_TIMEOUT_EN
                end else if (r_timer == 8'(GNT_TIMEOUT - 1)) begin
                    w_state_nxt = S_TURN;
                    w_last_nxt  = r_owner;
                    w_timeout   = 1'b1;
`endif
                end
            end
            S_BUSY: begin
                if (w_bus_idle) begin
                    if (w_owner_req && !w_other_req) begin
                        w_state_nxt = S_GRANT;
`ifdef ARB_GNT_TIMEOUT_EN
                        w_timer_nxt = 8'd0;
`endif
                    end else begin
                        w_state_nxt = S_TURN;
                    end
                end
            end
            default: w_state_nxt = S_TURN;
        endcase
    end

    // Output logic: values the registered outputs take in the next state.
    always_comb begin
        w_gnt_nxt  = '1;
        w_busy_nxt = (w_state_nxt == S_BUSY);
        case (w_state_nxt)
            S_PARK:  w_gnt_nxt = ~(ONE_HOT0 << PARK_MASTER);
            S_GRANT: w_gnt_nxt = ~(ONE_HOT0 << w_owner_nxt);
            S_BUSY: begin
                // Hidden arbitration: once dropped during BUSY the grant stays off
                // until the bus goes idle and a fresh decision is made.
                if (r_state == S_BUSY && (!w_owner_req || w_other_req)) begin
                    w_gnt_nxt = '1;
                end else begin
                    w_gnt_nxt = r_gnt_n;
                end
            end
            default: w_gnt_nxt = '1;
        endcase
    end

    assign bus.gnt_n    = r_gnt_n;
    assign bus.owner    = r_owner;
    assign bus.bus_busy = r_bus_busy;
`ifdef ARB_GNT_TIMEOUT_EN
    assign bus.timeout_err = r_timeout_err;
`else
    assign bus.timeout_err = 1'b0;
`endif
endmodule

// File: doc/pci_bus_arbiter.md
Name: pci_bus_arbiter

Overview:
- Central PCI arbiter that shares one PCI bus, and the target buffer behind it, among up to N bus masters.
- Takes active-low per-master REQ#, watches FRAME#/IRDY# for bus idle, and drives one-hot active-low GNT#.
- Arbitration is round-robin, with bus parking, a one-cycle grant turnaround and a grant-to-FRAME timeout.
- Sits beside the target buffer in the top level and never touches AD/CBE.

Parameters:
N_MASTERS, 4, number of requesters (2..8)
PARK_MASTER, 0, master granted when no requests are pending
GNT_TIMEOUT, 16, cycles a granted master has to assert FRAME# before its grant is revoked (2..255)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
req_n  input  N_MASTERS  per-master request, active low
frame_n  input  1  PCI FRAME#, active low
irdy_n  input  1  PCI IRDY#, active low
gnt_n  output  N_MASTERS  per-master grant, active low, at most one bit low, registered
owner  output  3  index of current or last granted master, registered
bus_busy  output  1  1 while the FSM is in BUSY, registered
timeout_err  output  1  one-cycle pulse on grant timeout (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=TURN, gnt_n all 1, owner=PARK_MASTER, last_owner=N_MASTERS-1, timer=0, bus_busy=0, timeout_err=0.
- Input sampling: all inputs are sampled at the rising edge. bus_idle = frame_n & irdy_n.
- Winner selection: first master with req_n=0, searching last_owner+1, +2, ... mod N_MASTERS. Combinational; used only in PARK, TURN and GRANT-exit decisions.
- States: PARK, TURN, GRANT, BUSY.
- TURN:
  - gnt_n all 1.
  - Next edge: if any request, go to GRANT with winner (owner=winner, timer=0). Otherwise go to PARK (owner=PARK_MASTER).
  - Always exactly one cycle.
- PARK:
  - gnt_n[PARK_MASTER]=0.
  - frame_n=0 sampled → BUSY (parked master started a transfer).
  - Else if winner==PARK_MASTER → GRANT, no turnaround, timer=0.
  - Else if any other request → TURN.
- GRANT:
  - gnt_n[owner]=0; timer increments each cycle.
  - frame_n=0 → BUSY, timer=0, last_owner=owner.
  - Else if req_n[owner]=1 → TURN (request withdrawn).
  - Else if timer==GNT_TIMEOUT-1 → TURN, last_owner=owner, timeout_err pulse.
  - Timeout and frame_n=0 on the same edge: frame wins, no timeout.
- BUSY:
  - bus_busy=1. gnt_n[owner] stays 0 while req_n[owner]=0.
  - If req_n[owner]=1, or another master requests, gnt_n goes all 1 at the next edge (hidden arbitration: no new grant while the bus is busy).
  - On the bus_idle edge: if req_n[owner]=0 and no other request → GRANT, same owner, timer=0. Otherwise → TURN.
- Grant switching rule: GNT# never moves directly from one master to another; at least one all-1 cycle always separates them.
- Reset mid-transaction: the FSM drops to TURN next edge and all grants deassert. The in-flight master finishes under its own FRAME#; the arbiter does not wait.
- Request withdrawn for one cycle in PARK/TURN: ignored unless sampled low at the decision edge.
- Invariants: owner always < N_MASTERS. At most one gnt_n bit is 0 in any cycle.

Optional Feature:
- Macro: ARB_GNT_TIMEOUT_EN.
- Defined: GRANT-state timer is active, revokes the grant after GNT_TIMEOUT idle cycles, and pulses timeout_err for one cycle.
- Undefined: no timer logic. GRANT waits indefinitely for frame_n or request withdrawal. timeout_err is tied 0.

Test Plan:
- Reset, then no requests: cycle 1 gnt_n=4'b1111 (TURN), then 4'b1110 (parked on master 0), owner=0, bus_busy=0, and it holds.
- Parked master 0 has req_n[0]=0 and drives frame_n=0 two cycles later: grant is never dropped; bus_busy=1 after the frame edge; after frame_n=irdy_n=1 with req released, gnt_n=1111 for one cycle, then 1110.
- req_n=4'b0101 (masters 1 and 3) from idle with last_owner=0: gnt_n 1110→1111→1101 (owner=1); master 1 transfers then releases; gnt_n 1111→0111 (owner=3). Verify round-robin order 1,3,1,3 under continuous requests.
- Master 2 requests, is granted, never asserts FRAME#, ARB_GNT_TIMEOUT_EN defined, GNT_TIMEOUT=16: grant drops after exactly 16 cycles low, timeout_err=1 for one cycle, and the next grant goes to master 3 if requesting. Without the macro, the grant holds for 100+ cycles and timeout_err stays 0.
- During a BUSY transfer by master 1, master 2 asserts req_n: gnt_n[1] deasserts next edge while FRAME# is still low; no gnt_n bit goes low until bus_idle is sampled; then one all-1 cycle; then gnt_n[2]=0.
- rst=1 for one cycle during BUSY: next edge gnt_n=all 1, bus_busy=0, owner=PARK_MASTER. Arbitration restarts normally once rst=0.
